// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the PC fetch unit and its next-PC mux.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam logic [1:0] NPC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] NPC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] NPC_SEL_JUMP   = 2'd2;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC priority select (jump > branch > PC+4).
// Also flags a non-word-aligned result.
module next_pc_mux
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc_plus4_i,
    input  logic             branch_taken_i,
    input  logic [WIDTH-1:0] branch_target_i,
    input  logic             jump_i,
    input  logic [WIDTH-1:0] jump_target_i,
    output logic [WIDTH-1:0] next_pc_o,
    output logic             misalign_o
);

    logic [1:0] sel;

    always_comb begin
        sel = NPC_SEL_PLUS4;
        if (jump_i) begin
            sel = NPC_SEL_JUMP;
        end else if (branch_taken_i) begin
            sel = NPC_SEL_BRANCH;
        end
    end

    always_comb begin
        next_pc_o = pc_plus4_i;
        case (sel)
            NPC_SEL_JUMP:   next_pc_o = jump_target_i;
            NPC_SEL_BRANCH: next_pc_o = branch_target_i;
            default:        next_pc_o = pc_plus4_i;
        endcase
    end

    assign misalign_o = |(next_pc_o[1:0] & WORD_ALIGN_MASK);

endmodule

// File: rtl/pc_fetch_unit.sv
// MIPS program counter with boot delay, stall hold,
// sticky misalignment halt and retired-instruction counter.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          BOOT_DELAY = 2,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic [WIDTH-1:0]     pc_plus4_i,
    input  logic                 branch_taken_i,
    input  logic [WIDTH-1:0]     branch_target_i,
    input  logic                 jump_i,
    input  logic [WIDTH-1:0]     jump_target_i,
    input  logic                 imem_ready_i,
    output logic [WIDTH-1:0]     pc_o,
    output logic                 imem_req_o,
    output logic                 fetch_valid_o,
    output logic                 misalign_o,
    output logic [CNT_WIDTH-1:0] instr_count_o
);

    localparam int BW = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_DELAY - 1);

    fetch_state_t state, state_nxt;
    logic [BW-1:0] boot_cnt;
    logic [WIDTH-1:0] next_pc;
    logic npc_misalign;
    logic advance;
    logic boot_done;

    next_pc_mux #(
        .WIDTH(WIDTH)
    ) u_next_pc_mux (
        .pc_plus4_i      (pc_plus4_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .next_pc_o       (next_pc),
        .misalign_o      (npc_misalign)
    );

    assign boot_done = (boot_cnt == BOOT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        imem_req_o    = 1'b0;
        fetch_valid_o = 1'b0;
        advance       = 1'b0;
        case (state)
            BOOT: begin
                if (boot_done) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                imem_req_o    = 1'b1;
                advance       = imem_ready_i & ~stall_i;
                fetch_valid_o = advance;
                if (advance && npc_misalign) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_cnt <= '0;
        end else if (state == BOOT && !boot_done) begin
            boot_cnt <= boot_cnt + BW'(1);
        end
    end

    // A misaligned target still retires the current instruction, but the PC is not updated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_o          <= WIDTH'(RESET_PC);
            misalign_o    <= 1'b0;
            instr_count_o <= '0;
        end else if (advance) begin
            instr_count_o <= instr_count_o + CNT_WIDTH'(1);
            if (npc_misalign) begin
                misalign_o <= 1'b1;
            end else begin
                pc_o <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit.
// Small counter width so wrap-around is reachable.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic [31:0] pc_plus4_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        imem_ready_i;
    logic [31:0] pc_o;
    logic        imem_req_o;
    logic        fetch_valid_o;
    logic        misalign_o;
    logic [3:0]  instr_count_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [3:0]  exp_cnt;
    logic        exp_mis;

    pc_fetch_unit #(
        .WIDTH      (32),
        .RESET_PC   (32'h0000_0000),
        .BOOT_DELAY (2),
        .CNT_WIDTH  (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .pc_plus4_i      (pc_plus4_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .imem_ready_i    (imem_ready_i),
        .pc_o            (pc_o),
        .imem_req_o      (imem_req_o),
        .fetch_valid_o   (fetch_valid_o),
        .misalign_o      (misalign_o),
        .instr_count_o   (instr_count_o)
    );

    assign pc_plus4_i = pc_o + 32'd4;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic rdy, input logic stl,
                       input logic jmp, input logic [31:0] jt,
                       input logic br, input logic [31:0] bt,
                       input logic e_req, input logic e_fv,
                       input logic [31:0] e_pc);
        imem_ready_i    = rdy;
        stall_i         = stl;
        jump_i          = jmp;
        jump_target_i   = jt;
        branch_taken_i  = br;
        branch_target_i = bt;
        #1;
        chk("req", {31'b0, imem_req_o}, {31'b0, e_req});
        chk("fv", {31'b0, fetch_valid_o}, {31'b0, e_fv});
        exp_q.push_back(e_pc);
        if (e_fv) exp_cnt = exp_cnt + 4'd1;
        @(posedge clk);
        #1;
        chk("pc", pc_o, exp_q.pop_front());
        chk("cnt", {28'b0, instr_count_o}, {28'b0, exp_cnt});
        chk("mis", {31'b0, misalign_o}, {31'b0, exp_mis});
        @(negedge clk);
    endtask

    task automatic adv(input logic [31:0] e_pc);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, e_pc);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"}, pc_o, 32'h0);
        chk({tag, "_req"}, {31'b0, imem_req_o}, 32'h0);
        chk({tag, "_fv"}, {31'b0, fetch_valid_o}, 32'h0);
        chk({tag, "_mis"}, {31'b0, misalign_o}, 32'h0);
        chk({tag, "_cnt"}, {28'b0, instr_count_o}, 32'h0);
    endtask

    task automatic boot();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b1;
        stall_i = 1'b0;
        imem_ready_i = 1'b1;
        jump_i = 1'b0;
        jump_target_i = 32'h0;
        branch_taken_i = 1'b0;
        branch_target_i = 32'h0;
        exp_cnt = 4'd0;
        exp_mis = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk_reset_state("rst");
        @(negedge clk);
        rst_n = 1'b1;

        boot();
        adv(32'h4);
        adv(32'h8);
        adv(32'hC);
        adv(32'h10);

        repeat (3)
            cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10);
        cyc(1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10);

        cyc(1'b1, 1'b0, 1'b1, 32'h400, 1'b1, 32'h200, 1'b1, 1'b1, 32'h400);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200);

        cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b1, 1'b1,
            32'hFFFF_FFF8);
        adv(32'hFFFF_FFFC);
        adv(32'h0);
        adv(32'h4);
        adv(32'h8);
        adv(32'hC);
        adv(32'h10);
        adv(32'h14);
        adv(32'h18);
        adv(32'h1C);
        chk("wrap_cnt", {28'b0, instr_count_o}, 32'h0);

        exp_mis = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h202, 1'b1, 1'b1, 32'h1C);
        repeat (2)
            cyc(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1C);

        rst_n = 1'b0;
        #2;
        chk_reset_state("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 4'd0;
        exp_mis = 1'b0;
        boot();
        cyc(1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80);

        #2 rst_n = 1'b0;
        #1;
        chk_reset_state("rst3");
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 4'd0;
        boot();
        adv(32'h4);

        chk("q_empty", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
